// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and the pattern-initialisation helper for the
//                LED pattern generator.
//  Revision    : 1.0
// ============================================================================
package led_pkg;

    // Widest LED bank the init helper handles; callers truncate the result.
    localparam int LED_W_MAX = 64;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_STATIC = 3'd1,
        MODE_ROTL   = 3'd2,
        MODE_ROTR   = 3'd3,
        MODE_BOUNCE = 3'd4,
        MODE_BLINK  = 3'd5,
        MODE_FILL   = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    typedef enum logic [0:0] {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic logic [LED_W_MAX-1:0] init_pattern(
        input mode_e                mode,
        input logic [LED_W_MAX-1:0] seed
    );
        logic [LED_W_MAX-1:0] w_pat;
        w_pat = '0;
        case (mode)
            MODE_ROTL, MODE_ROTR: w_pat = (seed == '0) ? LED_W_MAX'(1) : seed;
            MODE_BLINK, MODE_STATIC: w_pat = seed;
            MODE_BOUNCE:          w_pat = LED_W_MAX'(1);
            default:              w_pat = '0;
        endcase
        return w_pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen_if
//  Description : Control and LED-output bundle of the LED pattern generator.
//  Revision    : 1.0
// ============================================================================
interface led_pattern_gen_if #(
    parameter int N_LED = 16
);
    logic             en;
    logic [2:0]       mode;
    logic [1:0]       speed;
    logic [N_LED-1:0] seed;
    logic [N_LED-1:0] ledr;
    logic             tick;

    modport master (
        output en, mode, speed, seed,
        input  ledr, tick
    );

    modport slave (
        input  en, mode, speed, seed,
        output ledr, tick
    );
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Programmable prescaler producing the pattern step strobe.
//  Revision    : 1.0
// ============================================================================
module tick_gen #(
    parameter int DIV   = 5000000,
    parameter int CNT_W = $clog2(DIV) + 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    input  wire logic [1:0] speed,
    input  wire logic       clr,
    output logic            step
);
    localparam logic [CNT_W-1:0] c_div = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_shift;
    logic [CNT_W-1:0] w_limit;

    assign w_shift = c_div >> speed;
    assign w_limit = (w_shift == '0) ? c_one : w_shift;
    // >= rather than == so shortening the period mid-count never overruns.
    assign step    = en && (r_cnt >= (w_limit - c_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (step) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Animated LED bank driver (rotate, bounce, blink, fill).
//  Revision    : 1.0
// ============================================================================
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED = 16,
    parameter int DIV   = 5000000,
    parameter int CNT_W = $clog2(DIV) + 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    led_pattern_gen_if.slave  bus
);
    localparam logic [N_LED-1:0] c_one = N_LED'(1);

    mode_e            r_mode_q;
    dir_e             r_dir;
    logic             r_blink_on;
    logic [N_LED-1:0] r_ledr;
    logic             r_tick;

    mode_e            w_mode;
    logic             w_mode_chg;
    logic             w_step;
    logic [N_LED-1:0] w_init;
    logic [N_LED-1:0] w_next;
    dir_e             w_next_dir;
    logic             w_next_on;

    assign w_mode     = mode_e'(bus.mode);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign w_init     = N_LED'(init_pattern(w_mode, LED_W_MAX'(bus.seed)));

    tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .speed (bus.speed),
        .clr   (w_mode_chg),
        .step  (w_step)
    );

    always_comb begin
        w_next     = r_ledr;
        w_next_dir = r_dir;
        w_next_on  = r_blink_on;
        case (r_mode_q)
            MODE_ROTL: w_next = (r_ledr << 1) | (r_ledr >> (N_LED - 1));
            MODE_ROTR: w_next = (r_ledr >> 1) | (r_ledr << (N_LED - 1));
            MODE_BOUNCE: begin
                // A single LED has nowhere to walk, so it simply stays lit.
                if (N_LED == 1) begin
                    w_next = r_ledr;
                end else if (r_dir == DIR_LEFT) begin
                    if (r_ledr[N_LED-1]) begin
                        w_next_dir = DIR_RIGHT;
                        w_next     = r_ledr >> 1;
                    end else begin
                        w_next     = r_ledr << 1;
                    end
                end else begin
                    if (r_ledr[0]) begin
                        w_next_dir = DIR_LEFT;
                        w_next     = r_ledr << 1;
                    end else begin
                        w_next     = r_ledr >> 1;
                    end
                end
            end
            MODE_BLINK: begin
                w_next    = r_blink_on ? '0 : bus.seed;
                w_next_on = ~r_blink_on;
            end
            MODE_FILL: w_next = (&r_ledr) ? '0 : ((r_ledr << 1) | c_one);
            default:   w_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q   <= MODE_OFF;
            r_dir      <= DIR_LEFT;
            r_blink_on <= 1'b0;
            r_ledr     <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            // A mode change outranks any step due in the same cycle.
            if (w_mode_chg) begin
                r_mode_q   <= w_mode;
                r_dir      <= DIR_LEFT;
                r_blink_on <= 1'b1;
                r_ledr     <= w_init;
            end else begin
                case (r_mode_q)
                    MODE_STATIC:         r_ledr <= bus.seed;
                    MODE_OFF, MODE_RSVD: r_ledr <= '0;
                    default: begin
                        if (w_step) begin
                            r_ledr     <= w_next;
                            r_dir      <= w_next_dir;
                            r_blink_on <= w_next_on;
                            r_tick     <= 1'b1;
                        end else if ((r_mode_q == MODE_BLINK) && r_blink_on) begin
                            r_ledr <= bus.seed;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ledr = r_ledr;
    assign bus.tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen (N_LED=8, DIV=4).
//  Revision    : 1.0
// ============================================================================
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int N_LED  = 8;
    localparam int DIV_TB = 4;

    logic clk;
    logic rst;

    led_pattern_gen_if #(.N_LED(N_LED)) bus ();

    led_pattern_gen #(
        .N_LED (N_LED),
        .DIV   (DIV_TB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pattern is a pure function of steps taken since the
    // last mode change, the seed captured then, and the live seed.
    int m_mode, m_k, m_since, m_seed0, m_lim;
    int e_led, e_tick;
    bit m_stp;
    bit started = 1'b0;

    function automatic int pat(int md, int k, int s0, int sl);
        int s, r, p, pos;
        s = (s0 == 0) ? 1 : s0;
        r = k % N_LED;
        case (md)
            1: return sl;
            2: return ((s << r) | (s >> (N_LED - r))) & 255;
            3: return ((s >> r) | (s << (N_LED - r))) & 255;
            4: begin
                p   = k % (2 * (N_LED - 1));
                pos = (p <= N_LED - 1) ? p : 2 * (N_LED - 1) - p;
                return 1 << pos;
            end
            5: return (k % 2 == 0) ? sl : 0;
            6: return (1 << (k % (N_LED + 1))) - 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_mode = 0; m_k = 0; m_since = 0; e_led = 0; e_tick = 0;
        end else if (int'(bus.mode) != m_mode) begin
            m_mode  = int'(bus.mode);
            m_k     = 0;
            m_since = 0;
            m_seed0 = int'(bus.seed);
            e_led   = pat(m_mode, 0, m_seed0, int'(bus.seed));
            e_tick  = 0;
        end else begin
            e_tick = 0;
            m_lim  = DIV_TB >> bus.speed;
            if (m_lim < 1) m_lim = 1;
            m_stp = 1'b0;
            if (bus.en) begin
                m_since++;
                if (m_since >= m_lim) begin
                    m_since = 0;
                    m_stp   = 1'b1;
                end
            end
            if (m_mode == 1) e_led = int'(bus.seed);
            else if (m_mode == 0 || m_mode == 7) e_led = 0;
            else if (m_stp) begin
                m_k++;
                e_tick = 1;
                e_led  = pat(m_mode, m_k, m_seed0, int'(bus.seed));
            end else if (m_mode == 5 && (m_k % 2 == 0)) e_led = int'(bus.seed);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_ledr", 32'(bus.ledr), 32'(e_led));
            check("model_tick", 32'(bus.tick), 32'(e_tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [7:0] exp_led);
        check(name, 32'(bus.ledr), 32'(exp_led));
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.mode  = MODE_ROTL;
        bus.speed = 2'd0;
        bus.seed  = 8'h81;
        cyc(3);
        lit("reset_ledr", 8'h00);
        check("reset_tick", 32'(bus.tick), 32'd0);

        rst = 1'b0;
        cyc(1);  lit("rotl_init", 8'h81);
        cyc(4);  lit("rotl_step1", 8'h03);
        check("rotl_tick", 32'(bus.tick), 32'd1);
        cyc(4);  lit("rotl_step2", 8'h06);
        cyc(24); lit("rotl_wrap", 8'h81);

        bus.mode = MODE_ROTR;
        cyc(1);  lit("rotr_init", 8'h81);
        cyc(2);
        bus.en = 1'b0;
        cyc(10); lit("rotr_frozen", 8'h81);
        bus.en = 1'b1;
        cyc(1);  lit("rotr_resume_wait", 8'h81);
        cyc(1);  lit("rotr_resume_step", 8'hC0);

        bus.mode = MODE_BOUNCE;
        cyc(1);  lit("bounce_init", 8'h01);
        cyc(4);  lit("bounce_k1", 8'h02);
        cyc(24); lit("bounce_top", 8'h80);
        cyc(4);  lit("bounce_turn", 8'h40);
        cyc(24); lit("bounce_home", 8'h01);
        cyc(16); lit("bounce_mid", 8'h10);
        rst = 1'b1;
        cyc(1);  lit("bounce_rst", 8'h00);
        rst = 1'b0;
        cyc(1);  lit("bounce_reload", 8'h01);

        bus.mode = MODE_FILL;
        cyc(1);  lit("fill_init", 8'h00);
        cyc(4);  lit("fill_k1", 8'h01);
        cyc(28); lit("fill_full", 8'hFF);
        cyc(4);  lit("fill_wrap", 8'h00);
        bus.speed = 2'd3;
        cyc(1);  lit("fill_fast1", 8'h01);
        cyc(1);  lit("fill_fast2", 8'h03);
        bus.speed = 2'd0;
        cyc(6);

        bus.seed = 8'h5A;
        bus.mode = MODE_ROTL;
        cyc(1);  lit("rotl2_init", 8'h5A);
        cyc(3);
        bus.mode = MODE_BLINK;
        cyc(1);  lit("blink_init", 8'h5A);
        check("blink_no_tick", 32'(bus.tick), 32'd0);
        cyc(4);  lit("blink_off", 8'h00);
        cyc(4);  lit("blink_on", 8'h5A);

        bus.mode = MODE_STATIC;
        bus.seed = 8'h33;
        cyc(1);  lit("static_init", 8'h33);
        bus.seed = 8'hC4;
        cyc(1);  lit("static_live", 8'hC4);
        cyc(8);

        bus.mode = MODE_RSVD;
        cyc(1);  lit("rsvd_off", 8'h00);
        cyc(8);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the board LED driver.
- Drives an N_LED-wide LED bank with a selectable animated pattern: off, static, rotate left/right, bounce, blink or bar-fill.
- Steps at a programmable rate derived from the system clock.
- Sits between the switch-decoded mode/seed (from `sw` via top) and the `ledr` outputs.

Parameters:
- N_LED, 16, number of LEDs driven (>=1).
- DIV, 5000000, base clock cycles per pattern step at speed=0 (>=1).
- CNT_W, $clog2(DIV)+1, prescaler counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  1 = prescaler runs; 0 = freeze pattern and counter
- mode  input  3  pattern select (see Behaviour)
- speed  input  2  rate select; step period = max(DIV >> speed, 1) cycles
- seed  input  N_LED  initial/static pattern
- ledr  output  N_LED  registered LED pattern
- tick  output  1  one-cycle pulse, high in the cycle a step is applied to ledr

Behaviour:
- Clocking and reset:
  - Single clock domain, all state updated on the rising edge of clk.
  - rst is synchronous, active-high.
  - On rst: ledr=0, tick=0, prescaler cnt=0, mode_q=OFF, dir=LEFT.
  - A reset mid-pattern takes effect on the next edge and aborts the pattern; no state survives it.
- Prescaler:
  - limit = max(DIV >> speed, 1).
  - While en=1: if cnt >= limit-1 then cnt<=0 and a step is due; else cnt<=cnt+1.
  - The >= comparison means a speed change to a shorter period never overruns.
  - While en=0: cnt holds, no step, tick=0.
- Modes (mode_q is the registered mode):
  - 0 OFF: ledr=0.
  - 1 STATIC: ledr<=seed every cycle (1-cycle latency); prescaler ignored.
  - 2 ROTL: rotate left 1 per step; MSB wraps to LSB.
  - 3 ROTR: rotate right 1 per step; LSB wraps to MSB.
  - 4 BOUNCE: one lit bit walks toward MSB. At bit N_LED-1 the next step sets dir=RIGHT and moves to bit N_LED-2. At bit 0 with dir=RIGHT the next step sets dir=LEFT and moves to bit 1. With N_LED=1 the bit stays lit.
  - 5 BLINK: alternates between seed and 0 each step.
  - 6 FILL: bar graph: ledr<=(ledr<<1)|1 per step; all-ones steps to 0.
  - 7: reserved, behaves as OFF.
- Mode change:
  - Trigger: mode != mode_q at an edge.
  - At that edge: mode_q<=mode, cnt<=0, dir<=LEFT, no step, tick=0.
  - ledr<=init(mode), where init is:
    - ROTL/ROTR: seed, or 1 if seed==0.
    - BLINK: seed.
    - BOUNCE: 1.
    - FILL: 0.
    - OFF/7: 0.
    - STATIC: seed.
  - The first step follows `limit` cycles later.
  - A mode change in the same cycle a step is due wins; that step is discarded.
- seed changes inside an animated mode are not applied until the next mode change, except in STATIC and in BLINK's "on" phase, which use the live seed.
- tick=1 exactly in the cycle following the edge that applied a step, aligned with the new ledr value. STATIC and OFF never assert tick.
- All arithmetic is unsigned. Shifts are N_LED wide with no sign extension.

Decomposition:
- Package led_pkg:
  - mode enum (OFF, STATIC, ROTL, ROTR, BOUNCE, BLINK, FILL, RSVD).
  - dir enum (LEFT, RIGHT).
  - Helper function init_pattern(mode, seed).
- Sub-module tick_gen:
  - Parameters DIV, CNT_W.
  - Ports clk, rst, en, speed, clr.
  - Output step: the prescaler pulse.
  - clr is driven by mode-change detection.
- The top module holds mode_q, dir and the pattern register.

Test Plan (N_LED=8, DIV=4):
- rst=1 for 3 cycles with mode=ROTL, seed=0x81 -> ledr=0x00, tick=0 throughout. One edge after rst drops, ledr=0x81. Steps every 4 cycles: 0x03, 0x06, 0x0C, ... back to 0x81 after 8 ticks.
- mode=BOUNCE, speed=0 -> ledr sequence 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01 (returns after 14 ticks), tick period 4 cycles.
- mode=FILL -> 0x00, 0x01, 0x03, 0x07, ..., 0xFF, 0x00 (period 9 ticks). With speed=3, limit=max(0,1)=1, so tick fires every cycle.
- In ROTR, drive en=0 for 10 cycles -> ledr and cnt frozen, tick=0. Re-assert en -> the step lands exactly where the count left off.
- Change mode ROTL->BLINK (seed=0x5A) in the cycle a step is due -> no rotate applied, tick=0, ledr=0x5A next edge. Then 0x00, 0x5A, ... every 4 cycles.
- Assert rst for 1 cycle mid-BOUNCE at ledr=0x10 -> ledr=0x00. With mode held at BOUNCE, the next edge reloads 0x01 with dir=LEFT.
